// File: rtl/voice_allocator_if.sv
// Note-event handshake between the song/note source and the voice allocator.
// The source drives the note and its duration. The allocator answers with
// note_ready when it can take the event.
interface voice_allocator_if #(
   parameter int DUR_W = 6
) ();

   logic             note_valid;
   logic             note_ready;
   logic [5:0]       note_in;
   logic [DUR_W-1:0] dur_in;

   modport master (
      output note_valid,
      output note_in,
      output dur_in,
      input  note_ready
   );

   modport slave (
      input  note_valid,
      input  note_in,
      input  dur_in,
      output note_ready
   );

endinterface

// File: rtl/voice_allocator.sv
// Voice allocator: places incoming note events on the lowest free voice,
// latches the note for that voice, and strobes its load for one cycle.
// It counts each voice's duration down on play-enabled beats and releases
// the voice when the count expires. A note is back-pressured while every
// voice is busy or a flush is in progress.
module voice_allocator #(
   parameter int NUM_VOICES = 3,
   parameter int DUR_W      = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    play,
   input  logic                    flush,
   input  logic                    beat,
   voice_allocator_if.slave        note_bus,
   output logic [6*NUM_VOICES-1:0] voice_note,
   output logic [NUM_VOICES-1:0]   voice_load,
   output logic [NUM_VOICES-1:0]   voice_enable,
   output logic [NUM_VOICES-1:0]   busy,
   output logic                    note_done
);

   logic [DUR_W-1:0]        cnt      [NUM_VOICES];
   logic [DUR_W-1:0]        cnt_nxt  [NUM_VOICES];
   logic [NUM_VOICES-1:0]   busy_nxt;
   logic [6*NUM_VOICES-1:0] note_nxt;
   logic [NUM_VOICES-1:0]   free_sel;
   logic [NUM_VOICES-1:0]   load_mask;
   logic [NUM_VOICES-1:0]   expire;
   logic                    found_free;
   logic                    accept;
   logic                    alloc;
   logic                    tick;

   // Ready depends only on registered busy and flush. A voice freed on an
   // edge is therefore not offered until the following cycle.
   assign note_bus.note_ready = ~flush & ~(&busy);
   assign accept = note_bus.note_valid & note_bus.note_ready;
   assign alloc  = accept & (|note_bus.note_in) & (|note_bus.dur_in);
   assign tick   = beat & play;

   // Pick the lowest-index voice that is currently free.
   always_comb begin
      free_sel   = '0;
      found_free = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (!busy[i] && !found_free) begin
            free_sel[i] = 1'b1;
            found_free  = 1'b1;
         end
      end
   end

   assign load_mask = alloc ? free_sel : '0;

   // Next-state for every voice. Flush wins, then a new allocation, then the
   // beat countdown. A freshly loaded voice is never decremented on its load edge.
   always_comb begin
      busy_nxt = busy;
      cnt_nxt  = cnt;
      note_nxt = voice_note;
      expire   = '0;
      if (flush) begin
         busy_nxt = '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            cnt_nxt[i] = '0;
         end
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (load_mask[i]) begin
               busy_nxt[i]       = 1'b1;
               cnt_nxt[i]        = note_bus.dur_in;
               note_nxt[6*i +: 6] = note_bus.note_in;
            end else if (tick && busy[i]) begin
               if (cnt[i] == DUR_W'(1)) begin
                  busy_nxt[i] = 1'b0;
                  cnt_nxt[i]  = '0;
                  expire[i]   = 1'b1;
               end else begin
                  cnt_nxt[i] = cnt[i] - DUR_W'(1);
               end
            end
         end
      end
   end

   // Register voice state and the one-cycle strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy         <= '0;
         voice_note   <= '0;
         voice_load   <= '0;
         voice_enable <= '0;
         note_done    <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         busy         <= busy_nxt;
         voice_note   <= note_nxt;
         voice_load   <= load_mask;
         voice_enable <= busy & {NUM_VOICES{play}};
         note_done    <= |expire;
         for (int i = 0; i < NUM_VOICES; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator. A driver process applies stimulus and
// advances a behavioural model that tracks per-voice remaining beats. At each
// edge the model queues what the DUT should show in the following cycle. A
// monitor running on the falling edge pops those entries and compares them.
module tb_voice_allocator;

   localparam int NV = 3;
   localparam int DW = 6;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              play = 1'b1;
   logic              flush = 1'b0;
   logic              beat = 1'b0;
   logic [6*NV-1:0]   voice_note;
   logic [NV-1:0]     voice_load;
   logic [NV-1:0]     voice_enable;
   logic [NV-1:0]     busy;
   logic              note_done;

   voice_allocator_if #(.DUR_W(DW)) note_bus ();

   voice_allocator #(.NUM_VOICES(NV), .DUR_W(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .play         (play),
      .flush        (flush),
      .beat         (beat),
      .note_bus     (note_bus),
      .voice_note   (voice_note),
      .voice_load   (voice_load),
      .voice_enable (voice_enable),
      .busy         (busy),
      .note_done    (note_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NV-1:0]   busy;
      logic [NV-1:0]   en;
      logic [NV-1:0]   load;
      logic            done;
      logic [6*NV-1:0] notes;
   } exp_t;

   typedef struct {
      int voice;
      int note;
   } load_t;

   exp_t  stateQ[$];
   load_t loadQ[$];
   exp_t  monExp;
   load_t monLoad;

   bit mBusy [NV];
   int mRem  [NV];
   int mNote [NV];

   int checks = 0;
   int failures = 0;
   bit monOn = 0;
   bit lastAccept = 0;

   // Compare one observed value against the model's expectation.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance one clock edge. The model applies the allocation and countdown
   // rules to the inputs present at the edge.
   task automatic tickCycle();
      exp_t  e;
      load_t l;
      int    pick;
      bit    allBusy;
      bit    rdy;
      bit    tk;
      @(posedge clk);
      allBusy = 1;
      for (int i = 0; i < NV; i++) begin
         e.en[i] = mBusy[i] & play;
         if (!mBusy[i]) allBusy = 0;
      end
      rdy = !flush && !allBusy;
      tk = beat && play;
      e.done = 0;
      e.load = '0;
      lastAccept = note_bus.note_valid && rdy;
      if (flush) begin
         for (int i = 0; i < NV; i++) begin
            mBusy[i] = 0;
            mRem[i] = 0;
         end
      end else begin
         pick = -1;
         if (note_bus.note_valid && rdy && note_bus.note_in != 0 && note_bus.dur_in != 0) begin
            for (int i = 0; i < NV; i++) begin
               if (!mBusy[i] && pick < 0) pick = i;
            end
         end
         for (int i = 0; i < NV; i++) begin
            if (mBusy[i] && tk) begin
               if (mRem[i] == 1) begin
                  mBusy[i] = 0;
                  mRem[i] = 0;
                  e.done = 1;
               end else begin
                  mRem[i] = mRem[i] - 1;
               end
            end
         end
         if (pick >= 0) begin
            mBusy[pick] = 1;
            mRem[pick] = int'(note_bus.dur_in);
            mNote[pick] = int'(note_bus.note_in);
            e.load[pick] = 1'b1;
            l.voice = pick;
            l.note = int'(note_bus.note_in);
            loadQ.push_back(l);
         end
      end
      for (int i = 0; i < NV; i++) begin
         e.busy[i] = mBusy[i];
         e.notes[6*i +: 6] = 6'(mNote[i]);
      end
      stateQ.push_back(e);
      monOn = 1;
      #1;
   endtask

   // Drive one cycle of inputs and step the clock.
   task automatic applyStimulus(input bit v, input int n, input int d, input bit b, input bit p, input bit f);
      note_bus.note_valid = v;
      note_bus.note_in = 6'(n);
      note_bus.dur_in = DW'(d);
      beat = b;
      play = p;
      flush = f;
      tickCycle();
   endtask

   // Assert reset asynchronously, check the cleared state, then release it.
   task automatic applyReset();
      monOn = 0;
      note_bus.note_valid = 0;
      note_bus.note_in = '0;
      note_bus.dur_in = '0;
      beat = 0;
      flush = 0;
      play = 1;
      reset = 0;
      #2;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_load", voice_load, 0);
      checkOutput("rst_enable", voice_enable, 0);
      checkOutput("rst_note", voice_note, 0);
      checkOutput("rst_done", note_done, 0);
      checkOutput("rst_ready", note_bus.note_ready, 1);
      stateQ.delete();
      loadQ.delete();
      for (int i = 0; i < NV; i++) begin
         mBusy[i] = 0;
         mRem[i] = 0;
         mNote[i] = 0;
      end
      @(posedge clk);
      #1;
      reset = 1;
   endtask

   // Monitor: compare the DUT against the queued expectations each cycle,
   // and match each load strobe against the queued allocation.
   always @(negedge clk) begin
      if (monOn && reset) begin
         if (stateQ.size() == 0) begin
            checkOutput("state_queue_underflow", 1, 0);
         end else begin
            monExp = stateQ.pop_front();
            checkOutput("busy", busy, monExp.busy);
            checkOutput("voice_enable", voice_enable, monExp.en);
            checkOutput("voice_load", voice_load, monExp.load);
            checkOutput("note_done", note_done, monExp.done);
            checkOutput("voice_note", voice_note, monExp.notes);
            checkOutput("note_ready", note_bus.note_ready, (!flush && !(&monExp.busy)));
         end
         if (voice_load != 0) begin
            if (loadQ.size() == 0) begin
               checkOutput("unexpected_load", voice_load, 0);
            end else begin
               monLoad = loadQ.pop_front();
               checkOutput("load_voice", voice_load, 64'(1) << monLoad.voice);
               checkOutput("load_note", voice_note[6*monLoad.voice +: 6], monLoad.note);
            end
         end
      end
   end

   // Guard against a run that never reaches its end.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      note_bus.note_valid = 0;
      note_bus.note_in = '0;
      note_bus.dur_in = '0;
      applyReset();

      // Single note of three beats
      applyStimulus(1, 20, 3, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 0, 1, 1, 0);
         applyStimulus(0, 0, 0, 0, 1, 0);
      end
      applyStimulus(0, 0, 0, 0, 1, 0);

      // Fill all voices, then hold a fourth note until a voice frees up
      applyStimulus(1, 10, 5, 0, 1, 0);
      applyStimulus(1, 11, 5, 0, 1, 0);
      applyStimulus(1, 12, 5, 0, 1, 0);
      for (int k = 0; k < 30; k++) begin
         applyStimulus(1, 30, 5, (k % 3 == 0), 1, 0);
         if (lastAccept) break;
      end
      applyStimulus(0, 0, 0, 0, 1, 0);

      // Rest and zero-duration events are consumed without allocation
      applyStimulus(0, 0, 0, 0, 1, 1);
      applyStimulus(1, 0, 4, 0, 1, 0);
      applyStimulus(1, 9, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);

      // Pause freezes the countdown, resume releases after two beats
      applyStimulus(1, 5, 2, 0, 1, 0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 0, 1, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 0, 0, 1, 1, 0);
         applyStimulus(0, 0, 0, 0, 1, 0);
      end

      // Accept coincident with a beat, duration one
      applyStimulus(0, 0, 0, 0, 1, 1);
      applyStimulus(1, 7, 1, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);

      // All busy, then a single-cycle flush
      applyStimulus(1, 40, 9, 0, 1, 0);
      applyStimulus(1, 41, 9, 0, 1, 0);
      applyStimulus(1, 42, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 1, 0);

      // Reset arriving right after an accept edge
      note_bus.note_valid = 1;
      note_bus.note_in = 6'd33;
      note_bus.dur_in = DW'(4);
      tickCycle();
      applyReset();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 0, 1, 1, 0);
      end

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         int n;
         int d;
         n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 63));
         if ($urandom_range(0, 9) == 0) d = 0;
         else if ($urandom_range(0, 19) == 0) d = int'($urandom_range(1, 63));
         else d = int'($urandom_range(1, 6));
         if ($urandom_range(0, 599) == 0) begin
            applyReset();
         end
         applyStimulus(($urandom_range(0, 99) < 50), n, d,
                       ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 9) != 0),
                       ($urandom_range(0, 59) == 0));
      end
      applyStimulus(0, 0, 0, 0, 1, 0);

      @(negedge clk);
      #1;
      monOn = 0;
      checkOutput("state_queue_drained", stateQ.size(), 0);
      checkOutput("load_queue_drained", loadQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules incoming note events onto NUM_VOICES parallel note_player instances and owns each voice's note latch, load strobe, play enable and duration countdown.
- Sits between the song/note source and the bank of note_players. Each player's weight port and sample handshake bypass this block.
- Allocation is lowest-index-free-voice. A new note is back-pressured when every voice is busy.

Parameters:
- NUM_VOICES, 3, number of note_player voices managed (1..8)
- DUR_W, 6, width of a note duration in beats

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- play  in  1  global play/pause; 0 freezes all countdowns and gates enables
- flush  in  1  synchronous: release all voices
- beat  in  1  one-cycle tick per beat
- note_valid  in  1  note event offered
- note_ready  out  1  block can accept a note event this cycle
- note_in  in  6  note code; 0 = rest
- dur_in  in  DUR_W  duration in beats
- voice_note  out  6*NUM_VOICES  note per voice, voice i at bits [6i+5:6i]
- voice_load  out  NUM_VOICES  one-cycle load strobe per voice (drives load_new_note)
- voice_enable  out  NUM_VOICES  per-voice play_enable
- busy  out  NUM_VOICES  voice allocated mask
- note_done  out  1  one-cycle pulse when any voice is released by countdown

Behaviour:
- Reset (reset=0, async): busy=0, all duration counters=0, voice_note=0, voice_load=0, voice_enable=0, note_done=0. note_ready is 1 after reset release.
- Reset mid-operation: everything clears immediately. No load strobe is emitted afterward for a pending accept.
- note_ready = ~flush & ~(&busy), computed combinationally from the registered busy.
- Accept occurs on any edge where note_valid & note_ready.
- Accept with note_in!=0 and dur_in!=0:
  - select i = lowest index with busy[i]=0.
  - On that edge: busy[i]<=1, cnt[i]<=dur_in, voice_note[i]<=note_in.
  - voice_load[i]=1 for exactly the following cycle (latency 1).
- Accept with note_in=0 (rest) or dur_in=0: event is consumed with no allocation, no load, and no note_done.
- Countdown happens on an edge with beat=1 & play=1, per busy voice i:
  - Not loaded on this edge: cnt[i] decrements.
  - cnt[i]==1: busy[i]<=0, cnt[i]<=0, note_done pulses next cycle.
- A voice loaded on the same edge as a beat is not decremented on that beat.
- A voice released on an edge becomes allocatable on the next cycle, never on the same edge.
- Multiple voices expiring on the same beat produce a single note_done pulse.
- play=0: counters hold; voice_enable=0. Accepts are still allowed. voice_note and busy hold.
- voice_enable[i] = busy[i] & play (registered; follows busy/play with 1-cycle latency).
- voice_note[i] holds its last value after release. It does not clear until reallocated.
- flush=1 (synchronous, highest priority after reset):
  - busy<=0, counters<=0, no accept.
  - any voice_load scheduled for the next cycle is suppressed; no note_done.
- Only one accept per cycle. voice_load is therefore one-hot or zero.
- Width: counters are DUR_W bits, so maximum duration is 2^DUR_W-1 beats. No wrap can occur because the decrement stops at release.

Test Plan:
- Reset release → busy=000, note_ready=1. Offer note 20/dur 3 → next cycle voice_load=001, voice_note[0]=20. Three play=1 beats → busy=000 after the 3rd beat edge; note_done pulses once.
- Offer notes 10, 11, 12 (dur 5) back-to-back → loads 001, 010, 100 on consecutive cycles. note_ready=0 and a 4th note_valid is held. The 4th note (30) is accepted the cycle after voice 0 expires and lands in voice 0.
- Offer note 0/dur 4 and note 9/dur 0 → both accepted, no voice_load, busy unchanged.
- Voice holds dur 2; set play=0 and issue 4 beats → busy and cnt unchanged, voice_enable=0. Set play=1 and issue 2 beats → released.
- Accept coincident with a beat, dur 1 → voice stays busy through that beat and releases on the next beat.
- All voices busy, assert flush for 1 cycle → busy=000, note_ready=1 the following cycle, no note_done. Async reset pulsed during an accept → no voice_load afterward.
